// File: rtl/bit32_serial_sub.sv
// Serial 32-bit subtractor: A - B - Bin processed one nibble per clock over 8 cycles,
// with a start/busy/done handshake and a sign-extended 40-bit result.
module bit32_serial_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Bin,
  output logic        busy,
  output logic        done,
  output logic [39:0] Diff,
  output logic        Bout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic        borrow_q, borrow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bout_q, bout_d;
  logic [39:0] diff_q, diff_d;

  logic [3:0]  a_nib, b_nib, d_nib;
  logic        b_nxt;
  logic [4:0]  slice_base;

  // Shared nibble subtract cell; the counter selects which slice it sees.
  always_comb begin
    slice_base      = {cnt_q, 2'b00};
    a_nib           = a_q[slice_base +: 4];
    b_nib           = b_q[slice_base +: 4];
    {b_nxt, d_nib}  = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow_q};
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bout_d   = bout_q;
    diff_d   = diff_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          cnt_d    = 3'd0;
          acc_d    = 32'h0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d[slice_base +: 4] = d_nib;
        borrow_d               = b_nxt;
        cnt_d                  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Slice 7's nibble is not in acc_q yet, so splice it in directly.
          diff_d  = {{7{b_nxt}}, b_nxt, d_nib, acc_q[27:0]};
          bout_d  = b_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and accumulator registers are reset too, so an abort never leaves a stale borrow.
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      acc_q    <= 32'h0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      diff_q   <= 40'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
      diff_q   <= diff_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule
